// File: rtl/uart_xmit_arbiter_if.sv
// uart_xmit_arbiter_if: requester lanes plus the UART transmitter handshake shared by the arbiter
interface uart_xmit_arbiter_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic              busy;
    logic              xmitH;
    logic [7:0]        xmit_dataH;
    logic              xmit_doneH;

    modport master (
        input  req, req_data, xmit_doneH,
        output gnt, ack, err, busy, xmitH, xmit_dataH
    );

    modport slave (
        output req, req_data, xmit_doneH,
        input  gnt, ack, err, busy, xmitH, xmit_dataH
    );
endinterface

// File: rtl/uart_xmit_arbiter.sv
// uart_xmit_arbiter: round-robin sharing of one UART transmitter between NREQ byte sources
module uart_xmit_arbiter #(
    parameter int NREQ     = 4,
    parameter int START_TO = 8,
    parameter int FRAME_TO = 1023
) (
    input logic                 sys_clk,
    input logic                 sys_rst_l,
    uart_xmit_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, ACK, FAIL} state_t;

    state_t          state_q, state_d;
    logic [11:0]     timer_q, timer_d;
    logic [IW-1:0]   last_q, last_d, win_q, win_d, pick;
    logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
    logic            err_q, err_d, busy_q, busy_d, xmit_q, xmit_d;
    logic [7:0]      data_q, data_d;

    // winner search from last+1 upward; lower offsets overwrite higher ones so the nearest pending index wins
    always_comb begin
        pick = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[IW'((int'(last_q) + k) % NREQ)]) pick = IW'((int'(last_q) + k) % NREQ);
        end
    end

    // transaction sequencing; every output is computed here one cycle ahead and registered
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        last_d  = last_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        ack_d   = '0;
        err_d   = 1'b0;
        xmit_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.xmit_doneH && |bus.req) begin
                    win_d   = pick;
                    data_d  = bus.req_data[{pick, 3'b000} +: 8];
                    gnt_d   = NREQ'(1) << pick;
                    xmit_d  = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.xmit_doneH) begin
                    timer_d = '0;
                    state_d = WAIT_DONE;
                end else if (timer_q == 12'(START_TO)) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end else begin
                    timer_d = timer_q + 12'd1;
                end
            end
            WAIT_DONE: begin
                if (bus.xmit_doneH) begin
                    ack_d   = gnt_q;
                    state_d = ACK;
                end else if (timer_q == 12'(FRAME_TO)) begin
                    err_d   = 1'b1;
                    state_d = FAIL;
                end else begin
                    timer_d = timer_q + 12'd1;
                end
            end
            ACK, FAIL: begin
                gnt_d   = '0;
                last_d  = win_q;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                data_d  = '0;
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = state_d != IDLE;
    end

    // state and output registers; reset leaves requester 0 first in line
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q <= IDLE;
            timer_q <= '0;
            last_q  <= IW'(NREQ - 1);
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            xmit_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            last_q  <= last_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            xmit_q  <= xmit_d;
            data_q  <= data_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.ack        = ack_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;
    assign bus.xmitH      = xmit_q;
    assign bus.xmit_dataH = data_q;
endmodule

// File: tb/tb_uart_xmit_arbiter.sv
// tb_uart_xmit_arbiter: scoreboard bench with a behavioural UART transmitter model
module tb_uart_xmit_arbiter;
    localparam int NREQ      = 4;
    localparam int START_TO  = 8;
    localparam int FRAME_TO  = 20;
    localparam int FLEN      = 5;
    localparam int LAT_ACK   = 3 + FLEN;
    localparam int LAT_START = START_TO + 2;
    localparam int LAT_FRAME = FRAME_TO + 4;
    localparam int M_NORM    = 0;
    localparam int M_HIGH    = 1;
    localparam int M_LOW     = 2;

    typedef struct {int idx; logic [7:0] data;} launch_t;
    typedef struct {bit is_err; int idx; int lat;} comp_t;

    logic    sys_clk   = 1'b0;
    logic    sys_rst_l = 1'b0;
    int      checks = 0, failures = 0, cyc = 0, nlaunch = 0, last_launch = 0;
    int      mode = M_NORM, dly = 0, len = 0;
    launch_t lq[$];
    comp_t   cq[$];
    launch_t le;
    comp_t   ce;

    uart_xmit_arbiter_if #(.NREQ(NREQ)) bus();

    uart_xmit_arbiter #(.NREQ(NREQ), .START_TO(START_TO), .FRAME_TO(FRAME_TO)) dut (
        .sys_clk(sys_clk),
        .sys_rst_l(sys_rst_l),
        .bus(bus.master)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [31:0] oh(int i);
        return 32'(1) << i;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(string nm, logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h expected nothing (t=%0t)", nm, act, $time);
    endtask

    task automatic expect_txn(int idx, logic [7:0] d, bit is_err, int lat);
        lq.push_back('{idx, d});
        cq.push_back('{is_err, idx, lat});
    endtask

    task automatic wait_launches(int n);
        int target;
        target = nlaunch + n;
        for (int k = 0; k < 60 && nlaunch < target; k++) begin
            @(negedge sys_clk);
            #1;
        end
        if (nlaunch < target) fail("launch_timeout", 32'(nlaunch));
    endtask

    task automatic wait_quiet(int n);
        int k;
        for (k = 0; k < n; k++) begin
            @(posedge sys_clk);
            if (lq.size() == 0 && cq.size() == 0) break;
        end
        if (k == n) fail("quiet_timeout", 32'(lq.size() + cq.size()));
        @(negedge sys_clk);
        #1;
    endtask

    // transmitter model: done drops 2 cycles after the strobe, stays low FLEN cycles, or sticks per mode
    always @(negedge sys_clk) begin
        if (!sys_rst_l) begin
            bus.xmit_doneH = 1'b1;
            dly = 0;
            len = 0;
        end else if (bus.xmitH) begin
            dly = (mode == M_HIGH) ? 0 : 2;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                bus.xmit_doneH = 1'b0;
                len = (mode == M_LOW) ? -1 : FLEN;
            end
        end else if (len > 0) begin
            len--;
            if (len == 0) bus.xmit_doneH = 1'b1;
        end else if (len < 0 && mode != M_LOW) begin
            len = 0;
            bus.xmit_doneH = 1'b1;
        end
    end

    // monitor: pops the scoreboard whenever the DUT strobes a launch or a completion
    always @(negedge sys_clk) begin
        if (sys_rst_l) begin
            if (bus.xmitH) begin
                nlaunch++;
                last_launch = cyc;
                if (lq.size() == 0) fail("unexpected_launch", 32'(bus.gnt));
                else begin
                    le = lq.pop_front();
                    chk("launch_data", 32'(bus.xmit_dataH), 32'(le.data));
                    chk("launch_gnt", 32'(bus.gnt), oh(le.idx));
                    chk("launch_busy", 32'(bus.busy), 32'd1);
                end
            end
            if (bus.ack != '0 || bus.err) begin
                if (cq.size() == 0) fail("unexpected_done", 32'({bus.err, bus.ack}));
                else begin
                    ce = cq.pop_front();
                    chk("done_ack", 32'(bus.ack), ce.is_err ? 32'd0 : oh(ce.idx));
                    chk("done_err", 32'(bus.err), 32'(ce.is_err));
                    chk("done_gnt", 32'(bus.gnt), oh(ce.idx));
                    chk("done_latency", 32'(cyc - last_launch), 32'(ce.lat));
                end
            end
        end
    end

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(negedge sys_clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_xmit", 32'(bus.xmitH), 32'd0);
        chk("rst_data", 32'(bus.xmit_dataH), 32'd0);
        sys_rst_l = 1'b1;
        @(negedge sys_clk);
        #1;
        bus.req_data = 32'h0000_00A5;
        expect_txn(0, 8'hA5, 0, LAT_ACK);
        bus.req = 4'b0001;
        wait_launches(1);
        bus.req = '0;
        wait_quiet(100);
        chk("single_busy", 32'(bus.busy), 32'd0);
        chk("single_gnt", 32'(bus.gnt), 32'd0);
        #1 sys_rst_l = 1'b0;
        @(negedge sys_clk);
        #1 sys_rst_l = 1'b1;
        @(negedge sys_clk);
        #1;
        bus.req_data = 32'h4332_2110;
        expect_txn(0, 8'h10, 0, LAT_ACK);
        expect_txn(1, 8'h21, 0, LAT_ACK);
        expect_txn(2, 8'h32, 0, LAT_ACK);
        expect_txn(3, 8'h43, 0, LAT_ACK);
        expect_txn(0, 8'h10, 0, LAT_ACK);
        bus.req = 4'b1111;
        wait_launches(5);
        bus.req = '0;
        wait_quiet(200);
        mode = M_HIGH;
        bus.req_data = 32'h005C_0000;
        expect_txn(2, 8'h5C, 1, LAT_START);
        bus.req = 4'b0100;
        wait_launches(1);
        bus.req = '0;
        wait_quiet(100);
        chk("start_to_busy", 32'(bus.busy), 32'd0);
        chk("start_to_gnt", 32'(bus.gnt), 32'd0);
        mode = M_NORM;
        bus.req_data = 32'h3E00_0011;
        expect_txn(3, 8'h3E, 0, LAT_ACK);
        bus.req = 4'b1001;
        wait_launches(1);
        bus.req = '0;
        wait_quiet(100);
        mode = M_LOW;
        bus.req_data = 32'h0000_7E00;
        expect_txn(1, 8'h7E, 1, LAT_FRAME);
        bus.req = 4'b0010;
        wait_launches(1);
        bus.req = '0;
        wait_quiet(100);
        chk("frame_to_busy", 32'(bus.busy), 32'd0);
        bus.req_data = 32'h0000_0099;
        bus.req = 4'b0001;
        repeat (6) @(negedge sys_clk);
        #1;
        chk("blocked_busy", 32'(bus.busy), 32'd0);
        expect_txn(0, 8'h99, 0, LAT_ACK);
        mode = M_NORM;
        wait_launches(1);
        bus.req = '0;
        wait_quiet(100);
        bus.req_data = 32'h0000_C300;
        expect_txn(1, 8'hC3, 0, LAT_ACK);
        bus.req = 4'b0010;
        @(negedge sys_clk);
        #1;
        bus.req = '0;
        bus.req_data = 32'h0000_FF00;
        wait_quiet(100);
        bus.req_data = 32'h002D_0000;
        lq.push_back('{2, 8'h2D});
        bus.req = 4'b0100;
        wait_launches(1);
        bus.req = '0;
        for (int k = 0; k < 20 && bus.xmit_doneH; k++) begin
            @(negedge sys_clk);
            #1;
        end
        @(negedge sys_clk);
        #1;
        chk("mid_busy", 32'(bus.busy), 32'd1);
        chk("mid_gnt", 32'(bus.gnt), oh(2));
        #1 sys_rst_l = 1'b0;
        #1;
        chk("async_gnt", 32'(bus.gnt), 32'd0);
        chk("async_busy", 32'(bus.busy), 32'd0);
        chk("async_data", 32'(bus.xmit_dataH), 32'd0);
        chk("async_ack_err", 32'({bus.ack, bus.err, bus.xmitH}), 32'd0);
        repeat (2) @(negedge sys_clk);
        #1 sys_rst_l = 1'b1;
        bus.req_data = 32'h3F00_0001;
        expect_txn(0, 8'h01, 0, LAT_ACK);
        bus.req = 4'b1001;
        wait_launches(1);
        bus.req = '0;
        wait_quiet(100);
        expect_txn(3, 8'h3F, 0, LAT_ACK);
        bus.req = 4'b1000;
        wait_launches(1);
        bus.req = '0;
        wait_quiet(100);
        chk("launch_q_empty", 32'(lq.size()), 32'd0);
        chk("done_q_empty", 32'(cq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
